io_ready_ctrl: RTL and testbench

//   Second-generation Dock I/O cycle controller.
//   - Turns a qualified window hit into a one-hot /CS and a /READY hold toward the CPU.
//   - Adds over the first generation:
//       - parametrised slot count and synchroniser depth;
//       - per-slot enable mask;
//       - guaranteed minimum hold;
//       - watchdog timeout with bus-error reporting;
//       - saturating error counter.
//   - Sits between the window decoder (win_valid/sel_slot) and the slot connectors.

---
 rtl/dock_io_pkg.sv | 26 ++
 rtl/io_ready_ctrl_sync.sv | 31 +++
 rtl/io_ready_ctrl.sv | 145 ++++++++++++++
 tb/tb_io_ready_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dock_io_pkg.sv
// Dock I/O controller shared types.
// State encoding and slot decode helper.
package dock_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } io_state_t;

  localparam int unsigned MAX_SLOTS = 16;

  function automatic logic [MAX_SLOTS-1:0] onehot_slot(
    input int unsigned idx,
    input int unsigned n
  );
    logic [MAX_SLOTS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      r[i] = (idx == i) && (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/io_ready_ctrl_sync.sv
// Multi-flop synchroniser with async reset
// to a configurable value.
module sync_bits #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= RESET_VAL;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/io_ready_ctrl.sv
// Dock I/O cycle controller: slot chip select,
// READY hold with minimum wait, watchdog, error count.
module io_ready_ctrl
  import dock_io_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SEL_W = 3,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WAIT = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iorq_n,
  input  logic                 win_valid,
  input  logic [SEL_W-1:0]     sel_slot,
  input  logic [NUM_SLOTS-1:0] slot_en,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 err_clr,
  output logic [NUM_SLOTS-1:0] cs,
  output logic                 ready_n,
  output logic                 busy,
  output logic                 bus_err,
  output logic [SEL_W-1:0]     err_slot,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] TO_LAST = WC_W'(TIMEOUT_CYCLES - 1);

  io_state_t state;
  logic [WC_W-1:0] wcnt;
  logic [SEL_W-1:0] active_slot;
  logic [NUM_SLOTS-1:0] rdy_s;
  logic [MAX_SLOTS-1:0] oh_full;
  logic [NUM_SLOTS-1:0] sel_oh;
  logic hit, hit_ok, min_met, dev_ok, release_ok;
  logic timeout, err_evt;

  sync_bits #(
    .WIDTH(NUM_SLOTS),
    .STAGES(SYNC_STAGES),
    .RESET_VAL({NUM_SLOTS{1'b1}})
  ) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d(dev_ready_n),
    .q(rdy_s)
  );

  assign oh_full = onehot_slot(32'(sel_slot), 32'(NUM_SLOTS));
  assign sel_oh = oh_full[NUM_SLOTS-1:0];
  assign hit = !iorq_n && win_valid;
  assign hit_ok = |(sel_oh & slot_en);

  // cs holds the active slot's one-hot while in WAIT
  assign dev_ok = |(rdy_s & cs);
  assign min_met = (32'(wcnt) + 32'd1) >= 32'(MIN_WAIT);
  assign release_ok = min_met && dev_ok;
  assign timeout = (wcnt == TO_LAST) && !release_ok;

  assign err_evt =
    (state == IDLE && hit && !hit_ok) ||
    (state == WAIT && !iorq_n && timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cs <= '0;
      ready_n <= 1'b1;
      busy <= 1'b0;
      bus_err <= 1'b0;
      err_slot <= '0;
      wcnt <= '0;
      active_slot <= '0;
    end else begin
      bus_err <= err_evt;
      unique case (state)
        IDLE: begin
          if (hit && hit_ok) begin
            state <= WAIT;
            cs <= sel_oh;
            ready_n <= 1'b0;
            wcnt <= '0;
            active_slot <= sel_slot;
            busy <= 1'b1;
          end else if (hit) begin
            state <= ABORT;
            err_slot <= sel_slot;
            busy <= 1'b1;
          end
        end
        WAIT: begin
          if (iorq_n) begin
            state <= IDLE;
            cs <= '0;
            ready_n <= 1'b1;
            busy <= 1'b0;
          end else if (release_ok) begin
            state <= DONE;
            ready_n <= 1'b1;
          end else if (timeout) begin
            state <= ABORT;
            cs <= '0;
            ready_n <= 1'b1;
            err_slot <= active_slot;
          end else if (wcnt != '1) begin
            wcnt <= wcnt + WC_W'(1);
          end
        end
        DONE: begin
          if (iorq_n) begin
            state <= IDLE;
            cs <= '0;
            busy <= 1'b0;
          end
        end
        ABORT: begin
          if (iorq_n) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cs <= '0;
          ready_n <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_evt && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_io_ready_ctrl.sv
// Directed bench for io_ready_ctrl:
// hold, release, timeout, invalid slot, reset, saturation.
module tb_io_ready_ctrl;

  localparam int NS = 8;
  localparam int SW = 4;
  localparam int SS = 2;
  localparam int MW = 3;
  localparam int TO = 16;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic iorq_n;
  logic win_valid;
  logic [SW-1:0] sel_slot;
  logic [NS-1:0] slot_en;
  logic [NS-1:0] dev_ready_n;
  logic err_clr;
  logic [NS-1:0] cs;
  logic ready_n;
  logic busy;
  logic bus_err;
  logic [SW-1:0] err_slot;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int low_cnt;
  bit rel_seen;

  always #5 clk = ~clk;

  io_ready_ctrl #(
    .NUM_SLOTS(NS),
    .SEL_W(SW),
    .SYNC_STAGES(SS),
    .MIN_WAIT(MW),
    .TIMEOUT_CYCLES(TO),
    .ERR_CNT_W(EW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iorq_n(iorq_n),
    .win_valid(win_valid),
    .sel_slot(sel_slot),
    .slot_en(slot_en),
    .dev_ready_n(dev_ready_n),
    .err_clr(err_clr),
    .cs(cs),
    .ready_n(ready_n),
    .busy(busy),
    .bus_err(bus_err),
    .err_slot(err_slot),
    .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit(input int s);
    iorq_n = 1'b0;
    win_valid = 1'b1;
    sel_slot = SW'(s);
  endtask

  task automatic idle_bus();
    iorq_n = 1'b1;
    win_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iorq_n = 1'b1;
    win_valid = 1'b0;
    sel_slot = '0;
    slot_en = 8'hFF;
    dev_ready_n = 8'hFF;
    err_clr = 1'b0;
    tick();
    chk("rst_cs", 32'(cs), 0);
    chk("rst_ready_n", 32'(ready_n), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_err_slot", 32'(err_slot), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // 1: minimum wait on slot 2
    hit(2);
    tick();
    chk("t1_cs", 32'(cs), 32'h04);
    chk("t1_ready0", 32'(ready_n), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_ready1", 32'(ready_n), 0);
    tick();
    chk("t1_ready2", 32'(ready_n), 0);
    tick();
    chk("t1_release", 32'(ready_n), 1);
    chk("t1_cs_done", 32'(cs), 32'h04);
    idle_bus();
    tick();
    chk("t1_cs_drop", 32'(cs), 0);
    chk("t1_idle", 32'(busy), 0);
    hit(2);
    tick();
    chk("t1_b2b_cs", 32'(cs), 32'h04);
    idle_bus();
    tick();

    // 2: slot 5 held by device for 8 clocks
    dev_ready_n[5] = 1'b0;
    hit(5);
    tick();
    chk("t2_cs", 32'(cs), 32'h20);
    low_cnt = (ready_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (ready_n == 1'b0) low_cnt++;
    end
    dev_ready_n = 8'hFF;
    rel_seen = 1'b0;
    for (int i = 0; i < 10 && !rel_seen; i++) begin
      tick();
      if (ready_n == 1'b0) low_cnt++;
      else rel_seen = 1'b1;
    end
    chk("t2_released", 32'(rel_seen), 1);
    chk("t2_low_clocks", 32'(low_cnt), 32'(8 + SS));
    chk("t2_no_err", 32'(bus_err), 0);
    chk("t2_err_cnt", 32'(err_cnt), 0);
    dev_ready_n[5] = 1'b0;
    repeat (4) tick();
    chk("t2_done_ignores", 32'(ready_n), 1);
    dev_ready_n = 8'hFF;
    idle_bus();
    tick();
    chk("t2_cs_drop", 32'(cs), 0);

    // 3: watchdog on slot 1
    dev_ready_n[1] = 1'b0;
    hit(1);
    tick();
    repeat (TO - 1) tick();
    chk("t3_pre_ready", 32'(ready_n), 0);
    chk("t3_pre_err", 32'(bus_err), 0);
    tick();
    chk("t3_ready", 32'(ready_n), 1);
    chk("t3_cs", 32'(cs), 0);
    chk("t3_bus_err", 32'(bus_err), 1);
    chk("t3_err_slot", 32'(err_slot), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    hit(2);
    tick();
    chk("t3_pulse", 32'(bus_err), 0);
    chk("t3_abort_busy", 32'(busy), 1);
    chk("t3_abort_cs", 32'(cs), 0);
    dev_ready_n = 8'hFF;
    idle_bus();
    tick();
    chk("t3_idle", 32'(busy), 0);

    // 4: disabled slot and out-of-range slot
    slot_en = 8'hF7;
    hit(3);
    tick();
    chk("t4_cs", 32'(cs), 0);
    chk("t4_ready", 32'(ready_n), 1);
    chk("t4_bus_err", 32'(bus_err), 1);
    chk("t4_err_slot", 32'(err_slot), 3);
    chk("t4_err_cnt", 32'(err_cnt), 2);
    idle_bus();
    tick();
    slot_en = 8'hFF;
    hit(9);
    tick();
    chk("t4r_cs", 32'(cs), 0);
    chk("t4r_bus_err", 32'(bus_err), 1);
    chk("t4r_err_slot", 32'(err_slot), 9);
    chk("t4r_err_cnt", 32'(err_cnt), 3);
    tick();
    chk("t4r_pulse", 32'(bus_err), 0);
    idle_bus();
    tick();

    // 5: iorq_n rise wins over timeout, then async reset
    dev_ready_n[1] = 1'b0;
    hit(1);
    tick();
    repeat (TO - 1) tick();
    idle_bus();
    tick();
    chk("t5_no_err", 32'(bus_err), 0);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_cs", 32'(cs), 0);
    chk("t5_err_cnt", 32'(err_cnt), 3);
    dev_ready_n = 8'hFF;
    tick();
    hit(6);
    tick();
    tick();
    chk("t5_wait_cs", 32'(cs), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(cs), 0);
    chk("t5_rst_ready", 32'(ready_n), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_err_slot", 32'(err_slot), 0);
    chk("t5_rst_err_cnt", 32'(err_cnt), 0);
    idle_bus();
    tick();
    rst_n = 1'b1;
    tick();

    // 6: counter saturation and clear priority
    for (int i = 0; i < 5; i++) begin
      hit(9);
      tick();
      idle_bus();
      tick();
    end
    chk("t6_sat", 32'(err_cnt), 3);
    hit(9);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_clr_err", 32'(bus_err), 1);
    chk("t6_clr_cnt", 32'(err_cnt), 0);
    idle_bus();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
